dmem_stage: RTL and testbench
=============================

# dmem_stage

Parametrised MEM stage of the tiny MIPS pipeline: byte-addressable data memory with sub-word loads/stores, configurable access latency with pipeline stall, and the MEM/WB pipeline register. It sits between the EX/MEM register and write-back. Control and data from EX/MEM arrive as `xm_*` inputs; registered results leave as `mw_*` outputs.

## Interface
- `ADDR_W`, 7: word-address bits; `DEPTH = 2**ADDR_W` words of 32 bits.
- `LAT`, 0: extra wait cycles per memory access, legal range 0..15.
- `RD_W`, 5: destination register index width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `xm_memtoreg`, `xm_regwrite`, `xm_memread`, `xm_memwrite` in 1 each: control bits from EX/MEM.
- `xm_size` in 2: access size; 00 byte, 01 half, 10 word, 11 is treated as word.
- `xm_unsigned` in 1: zero-extend sub-word loads when 1, sign-extend when 0.
- `alu_out` in 32: byte address and pass-through ALU result.
- `xm_rd` in RD_W: destination register.
- `xm_md` in 32: store data, right-aligned.
- `mem_stall` out 1: EX/MEM and upstream stages must hold while this is high.
- `mw_memtoreg`, `mw_regwrite` out 1: registered control.
- `mw_aluout` out 32: registered `alu_out`.
- `mdr` out 32: extended load data.
- `mw_rd` out RD_W: registered destination.
- `mw_misalign` out 1: registered misalignment flag; tied 0 without the macro.

## Operation
- Address decode:
  - Word index = `alu_out[ADDR_W+1:2]`.
  - Byte offset = `alu_out[1:0]`.
  - Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- An access is `xm_memread | xm_memwrite`. If both are set, the access is a write and `mdr` holds its value.
- Stores write only the addressed lanes:
  - Byte: `xm_md[7:0]` to lane offset.
  - Half: `xm_md[15:0]` to lanes offset, offset+1.
  - Word: all four lanes.
  - Other lanes are unchanged.
- Loads extract the addressed byte or half, then extend to 32 bits per `xm_unsigned`. Word loads pass through unchanged.
- `mdr` updates only on a completing read; otherwise it holds.
- FSM has two states, IDLE and WAIT, plus counter `cnt` (4 bits).
  - IDLE, access present, LAT>0: `mem_stall`=1 combinationally; next state WAIT; `cnt`←LAT-1.
  - IDLE, access present, LAT=0: access completes this edge; state stays IDLE.
  - WAIT, `cnt`≠0: `mem_stall`=1; `cnt` decrements.
  - WAIT, `cnt`=0: `mem_stall`=0; access completes this edge; next state IDLE.
- Upstream holds all `xm_*` inputs stable while `mem_stall`=1.
- While `mem_stall`=1, the MEM/WB register loads a bubble: `mw_regwrite`=0, `mw_memtoreg`=0, `mw_misalign`=0. `mw_aluout`, `mw_rd` and `mdr` hold.
- Non-access instructions pass through in one cycle with no stall.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All `mw_*` outputs, `mdr` and `cnt` go to 0; state goes to IDLE.
  - All memory words are cleared.
  - `mem_stall` is 0 during reset.
  - Reset asserted in WAIT aborts the access; no memory write occurs.
- Access latency is LAT+1 cycles, with `mem_stall` high for exactly LAT cycles.
- Store data commits at the completing edge. A load in the following cycle sees the new data.
- Back-to-back accesses each incur the full LAT stall; no pipelining between accesses.
- Results appear on `mw_*`/`mdr` one edge after completion, i.e. the registered MEM/WB boundary.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means half at an odd offset, or word at offset ≠ 0.
  - A misaligned access performs no memory read or write and takes no stall (completes from IDLE immediately).
  - It registers `mw_misalign`=1 and forces `mw_regwrite`=0 for that instruction.
- Undefined:
  - Low offset bits are masked: half uses `offset & 2'b10`, word uses 0 (aligned down).
  - `mw_misalign` is constant 0.

## Structure
- Shared package `tiny_mips_pkg` holds:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - FSM state typedef (`ST_IDLE`, `ST_WAIT`).
  - Lane-mask constants.
- Sub-module `dmem_bank` contains:
  - DEPTH×32 array with per-byte write enables and asynchronous read port.
  - Clear-on-reset behaviour.
- `dmem_stage` contains:
  - Decode, lane-mask generation, extension, FSM and pipeline register.

## Test plan
- LAT=0, `sw` 0xDEADBEEF to 0x10, then `lw` 0x10 → `mdr`=0xDEADBEEF one edge later; `mem_stall` never high.
- `sb` 0x80 to 0x13, then `lb` 0x13 → `mdr`=0xFFFFFF80. Then `lbu` 0x13 → 0x00000080. `lw` 0x10 → 0x80ADBEEF.
- `sh` 0x1234 to 0x22, then `lhu` 0x22 → 0x00001234; `lw` 0x20 → 0x12340000.
- LAT=3, `lw` → `mem_stall` high exactly 3 cycles; bubble (`mw_regwrite`=0) during stall; data on the 4th edge. Reset in cycle 2 → outputs 0, state IDLE, no write.
- With macro, `lw` at 0x22 → `mw_misalign`=1, `mw_regwrite`=0, `mdr` unchanged. Without macro → reads word 0x20.
- Address 0x210 with ADDR_W=7 wraps to word 4; both read and write hit word 4.

Source files
------------

// File: rtl/tiny_mips_pkg.sv
// Shared definitions for the tiny MIPS pipeline: access sizes, MEM-stage FSM
// states and byte-lane masks.
package tiny_mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dmem_state_t;

    localparam logic [3:0] LANE_B0 = 4'b0001;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;

    // Byte-lane enables for an access; the offset must already be aligned.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = LANE_B0 << off;
            SZ_HALF: m = off[1] ? LANE_H1 : LANE_H0;
            default: m = LANE_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data memory: per-byte write enables, asynchronous read,
// whole array cleared by reset.
import tiny_mips_pkg::*;

module dmem_bank #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_stage.sv
// MEM stage: sub-word load/store, LAT-cycle access stall and MEM/WB register.
// Optional macro DMEM_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
//
// state   | meaning
// ST_IDLE | no access in flight; LAT=0 or trapped accesses complete here
// ST_WAIT | access in flight; completes when r_cnt reaches 0
import tiny_mips_pkg::*;

module dmem_stage #(
    parameter int ADDR_W = 7,
    parameter int LAT    = 0,
    parameter int RD_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            xm_memtoreg,
    input  logic            xm_regwrite,
    input  logic            xm_memread,
    input  logic            xm_memwrite,
    input  logic [1:0]      xm_size,
    input  logic            xm_unsigned,
    input  logic [31:0]     alu_out,
    input  logic [RD_W-1:0] xm_rd,
    input  logic [31:0]     xm_md,
    output logic            mem_stall,
    output logic            mw_memtoreg,
    output logic            mw_regwrite,
    output logic [31:0]     mw_aluout,
    output logic [31:0]     mdr,
    output logic [RD_W-1:0] mw_rd,
    output logic            mw_misalign
);

    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    dmem_state_t     r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            w_stall, w_complete;
    logic            w_access, w_misalign;
    logic            w_is_half, w_is_word;
    logic [1:0]      w_off, w_eff_off;
    logic [3:0]      w_we;
    logic [31:0]     w_wdata, w_rdata, w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            r_memtoreg, r_regwrite, r_misalign;
    logic [31:0]     r_aluout, r_mdr;
    logic [RD_W-1:0] r_rd;
    logic            w_unused_hi;

    assign w_unused_hi = ^alu_out[31:ADDR_W+2];

    assign w_access  = xm_memread | xm_memwrite;
    assign w_off     = alu_out[1:0];
    assign w_is_half = (xm_size == SZ_HALF);
    assign w_is_word = xm_size[1];
    // Aligned-down offset; for a legal access it equals the raw offset.
    assign w_eff_off = w_is_word ? 2'b00 : (w_is_half ? {w_off[1], 1'b0} : w_off);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = w_access & ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_misalign || LAT == 0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_complete  = w_access;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign mem_stall = w_stall & rst_n;

    assign w_we    = (w_complete & xm_memwrite & ~w_misalign) ? lane_mask(xm_size, w_eff_off) : 4'b0000;
    assign w_wdata = (xm_size == SZ_BYTE) ? {4{xm_md[7:0]}} :
                     (xm_size == SZ_HALF) ? {2{xm_md[15:0]}} : xm_md;

    dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_addr  (alu_out[ADDR_W+1:2]),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_byte = w_rdata[{w_eff_off, 3'b000} +: 8];
    assign w_half = w_eff_off[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_load = w_rdata;
        case (xm_size)
            SZ_BYTE: w_load = xm_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load = xm_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_rdata;
        endcase
    end

    // MEM/WB register; a stall inserts a bubble and holds the data fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
            r_aluout   <= '0;
            r_rd       <= '0;
            r_mdr      <= '0;
        end else if (w_stall) begin
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_memtoreg <= xm_memtoreg;
            r_regwrite <= xm_regwrite & ~w_misalign;
            r_misalign <= w_misalign;
            r_aluout   <= alu_out;
            r_rd       <= xm_rd;
            if (w_complete && xm_memread && !xm_memwrite && !w_misalign) begin
                r_mdr <= w_load;
            end
        end
    end

    assign mw_memtoreg = r_memtoreg;
    assign mw_regwrite = r_regwrite;
    assign mw_misalign = r_misalign;
    assign mw_aluout   = r_aluout;
    assign mw_rd       = r_rd;
    assign mdr         = r_mdr;

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: two instances (LAT=0 and LAT=3) checked against a
// byte-array reference model of the data memory and the MEM/WB register.
module tb_dmem_stage;

    localparam int LATV [2] = '{0, 3};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        memtoreg_i[2], regwrite_i[2], memread[2], memwrite[2], uns[2];
    logic [1:0]  size      [2];
    logic [31:0] aluo      [2], md[2];
    logic [4:0]  rd_i      [2];
    logic        stall     [2], mw_m2r[2], mw_rw[2], mw_mis[2];
    logic [31:0] mw_alu    [2], mdr[2];
    logic [4:0]  mw_rd     [2];

    dmem_stage #(.ADDR_W(7), .LAT(0), .RD_W(5)) u_lat0 (
        .clk(clk), .rst_n(rst_n[0]),
        .xm_memtoreg(memtoreg_i[0]), .xm_regwrite(regwrite_i[0]),
        .xm_memread(memread[0]), .xm_memwrite(memwrite[0]),
        .xm_size(size[0]), .xm_unsigned(uns[0]), .alu_out(aluo[0]),
        .xm_rd(rd_i[0]), .xm_md(md[0]), .mem_stall(stall[0]),
        .mw_memtoreg(mw_m2r[0]), .mw_regwrite(mw_rw[0]), .mw_aluout(mw_alu[0]),
        .mdr(mdr[0]), .mw_rd(mw_rd[0]), .mw_misalign(mw_mis[0])
    );

    dmem_stage #(.ADDR_W(7), .LAT(3), .RD_W(5)) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]),
        .xm_memtoreg(memtoreg_i[1]), .xm_regwrite(regwrite_i[1]),
        .xm_memread(memread[1]), .xm_memwrite(memwrite[1]),
        .xm_size(size[1]), .xm_unsigned(uns[1]), .alu_out(aluo[1]),
        .xm_rd(rd_i[1]), .xm_md(md[1]), .mem_stall(stall[1]),
        .mw_memtoreg(mw_m2r[1]), .mw_regwrite(mw_rw[1]), .mw_aluout(mw_alu[1]),
        .mdr(mdr[1]), .mw_rd(mw_rd[1]), .mw_misalign(mw_mis[1])
    );

    logic [7:0]  ref_mem [2][512];
    logic [31:0] ref_mdr [2];
    int total = 0;
    int bad   = 0;

    task automatic model_clear(input int d);
        for (int i = 0; i < 512; i++) ref_mem[d][i] = 8'h00;
        ref_mdr[d] = 32'h0;
    endtask

    // Memory as a flat little-endian byte array; addresses wrap at 128 words.
    task automatic model_op(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic un, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic mis);
        int w, off, n, base;
        logic [31:0] v;
        w   = int'((addr >> 2) % 128);
        off = int'(addr % 4);
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (rd | wr) && (off % n != 0);
`endif
        off  = off - (off % n);
        base = w * 4 + off;
        if (!mis && wr) begin
            for (int i = 0; i < n; i++) ref_mem[d][base + i] = 8'(wdata >> (8 * i));
        end else if (!mis && rd) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][base + i]) << (8 * i));
            if (n < 4 && !un && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            ref_mdr[d] = v;
        end
    endtask

    // Issue one instruction, follow it through any stall, and leave the bench
    // just after the edge that loads its MEM/WB result.
    task automatic do_op(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic un, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rw, input logic m2r, input logic [4:0] rdi,
                         output int stalls, output int bubble_bad, output logic mis);
        stalls = 0;
        bubble_bad = 0;
        @(negedge clk);
        memread[d] = rd; memwrite[d] = wr; size[d] = sz; uns[d] = un;
        aluo[d] = addr; md[d] = wdata; regwrite_i[d] = rw; memtoreg_i[d] = m2r; rd_i[d] = rdi;
        #1;
        while (stall[d] === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
            if (mw_rw[d] !== 1'b0 || mw_m2r[d] !== 1'b0 || mw_mis[d] !== 1'b0) bubble_bad++;
        end
        @(posedge clk); #1;
        model_op(d, rd, wr, sz, un, addr, wdata, mis);
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            memread[d] = 1'b0; memwrite[d] = 1'b0; size[d] = 2'd0; uns[d] = 1'b0;
            aluo[d] = 32'h0; md[d] = 32'h0; regwrite_i[d] = 1'b0; memtoreg_i[d] = 1'b0; rd_i[d] = 5'd0;
            model_clear(d);
        end
        memread[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (stall[d] !== 1'b0 || mw_rw[d] !== 1'b0 || mw_m2r[d] !== 1'b0 || mw_mis[d] !== 1'b0 ||
                mw_alu[d] !== 32'h0 || mdr[d] !== 32'h0 || mw_rd[d] !== 5'd0) begin
                bad++;
                $display("FAIL reset_state d=%0d: stall=%b rw=%b m2r=%b mis=%b alu=%h mdr=%h rd=%h, required all zero",
                         d, stall[d], mw_rw[d], mw_m2r[d], mw_mis[d], mw_alu[d], mdr[d], mw_rd[d]);
            end
        end
        memread[1] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
    endtask

    task automatic test_word_lat0;
        int s, bb; logic mis;
        do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, s, bb, mis);
        do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd9, s, bb, mis);
        total++;
        if (mdr[0] !== 32'hDEADBEEF || s != 0) begin
            bad++;
            $display("FAIL lw_lat0: mdr=%h stalls=%0d, required DEADBEEF and 0", mdr[0], s);
        end
        total++;
        if (mw_rw[0] !== 1'b1 || mw_m2r[0] !== 1'b1 || mw_rd[0] !== 5'd9 || mw_alu[0] !== 32'h10) begin
            bad++;
            $display("FAIL lw_lat0_ctrl: rw=%b m2r=%b rd=%0d alu=%h, required 1 1 9 00000010",
                     mw_rw[0], mw_m2r[0], mw_rd[0], mw_alu[0]);
        end
    endtask

    task automatic test_subword;
        int s, bb; logic mis;
        logic [31:0] exp_v [5];
        string nm [5];
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'h00001234, 32'h12340000};
        nm    = '{"lb", "lbu", "lw_after_sb", "lhu", "lw_after_sh"};
        do_op(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b0, 1'b0, 5'd0, s, bb, mis);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: do_op(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 5'd1, s, bb, mis);
                1: do_op(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 1'b1, 5'd2, s, bb, mis);
                2: do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd3, s, bb, mis);
                3: begin
                    do_op(0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 1'b0, 1'b0, 5'd0, s, bb, mis);
                    do_op(0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 1'b1, 5'd4, s, bb, mis);
                end
                default: do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd5, s, bb, mis);
            endcase
            total++;
            if (mdr[0] !== exp_v[k]) begin
                bad++;
                $display("FAIL %s: mdr=%h, required %h", nm[k], mdr[0], exp_v[k]);
            end
        end
        // Misaligned word load: trapped with the macro, aligned down without it.
        do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 1'b1, 5'd6, s, bb, mis);
        total++;
        if (mdr[0] !== 32'h12340000 || mw_mis[0] !== mis || mw_rw[0] !== !mis) begin
            bad++;
            $display("FAIL lw_misaligned: mdr=%h mis=%b rw=%b, required 12340000 %b %b",
                     mdr[0], mw_mis[0], mw_rw[0], mis, !mis);
        end
    endtask

    task automatic test_wrap;
        int s, bb; logic mis;
        do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h210, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0, s, bb, mis);
        do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd7, s, bb, mis);
        total++;
        if (mdr[0] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL wrap_write: mdr=%h, required CAFEF00D", mdr[0]);
        end
        do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0BADC0DE, 1'b0, 1'b0, 5'd0, s, bb, mis);
        do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h210, 32'h0, 1'b1, 1'b0, 5'd7, s, bb, mis);
        total++;
        if (mdr[0] !== 32'h0BADC0DE) begin
            bad++;
            $display("FAIL wrap_read: mdr=%h, required 0BADC0DE", mdr[0]);
        end
    endtask

    task automatic test_latency;
        int s, bb; logic mis;
        do_op(1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5_1234, 1'b0, 1'b0, 5'd0, s, bb, mis);
        total++;
        if (s != 3 || bb != 0) begin
            bad++;
            $display("FAIL sw_lat3: stalls=%0d bubble_errors=%0d, required 3 and 0", s, bb);
        end
        for (int k = 0; k < 2; k++) begin
            do_op(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'(10 + k), s, bb, mis);
            total++;
            if (s != 3 || bb != 0 || mdr[1] !== 32'hA5A5_1234 || mw_rw[1] !== 1'b1 || mw_rd[1] !== 5'(10 + k)) begin
                bad++;
                $display("FAIL lw_lat3_%0d: stalls=%0d bubble_errors=%0d mdr=%h rw=%b rd=%0d, required 3 0 A5A51234 1 %0d",
                         k, s, bb, mdr[1], mw_rw[1], mw_rd[1], 10 + k);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        int s, bb; logic mis;
        @(negedge clk);
        memread[1] = 1'b0; memwrite[1] = 1'b1; size[1] = 2'd2; aluo[1] = 32'h40;
        md[1] = 32'h55AA_55AA; regwrite_i[1] = 1'b0; memtoreg_i[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (stall[1] !== 1'b1) begin
            bad++;
            $display("FAIL stall_before_reset: stall=%b, required 1", stall[1]);
        end
        rst_n[1] = 1'b0;
        #1;
        total++;
        if (stall[1] !== 1'b0 || mw_rw[1] !== 1'b0 || mdr[1] !== 32'h0 || mw_alu[1] !== 32'h0 || mw_rd[1] !== 5'd0) begin
            bad++;
            $display("FAIL reset_in_wait: stall=%b rw=%b mdr=%h alu=%h rd=%0d, required all zero",
                     stall[1], mw_rw[1], mdr[1], mw_alu[1], mw_rd[1]);
        end
        memwrite[1] = 1'b0;
        model_clear(1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        do_op(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 5'd3, s, bb, mis);
        total++;
        if (mdr[1] !== 32'h0 || s != 3) begin
            bad++;
            $display("FAIL no_write_after_abort: mdr=%h stalls=%0d, required 0 and 3", mdr[1], s);
        end
        do_op(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 5'd3, s, bb, mis);
        total++;
        if (mdr[1] !== 32'h0) begin
            bad++;
            $display("FAIL mem_cleared: mdr=%h, required 0", mdr[1]);
        end
    endtask

    task automatic test_random;
        int s, bb, exp_s; logic mis;
        logic rd, wr, un, rw, m2r;
        logic [1:0] sz;
        logic [31:0] addr, wdata;
        logic [4:0] rdi;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                rd = 1'($urandom); wr = 1'($urandom); sz = 2'($urandom); un = 1'($urandom);
                rw = 1'($urandom); m2r = 1'($urandom); rdi = 5'($urandom);
                addr = 32'($urandom_range(0, 47));
                if ($urandom_range(0, 3) == 0) addr = addr | (32'($urandom) << 9);
                wdata = $urandom;
                do_op(d, rd, wr, sz, un, addr, wdata, rw, m2r, rdi, s, bb, mis);
                exp_s = ((rd | wr) && !mis) ? LATV[d] : 0;
                total++;
                if (s != exp_s || bb != 0 || mdr[d] !== ref_mdr[d] || mw_rw[d] !== (rw & !mis) ||
                    mw_m2r[d] !== m2r || mw_alu[d] !== addr || mw_rd[d] !== rdi || mw_mis[d] !== mis) begin
                    bad++;
                    $display("FAIL random d=%0d n=%0d: stalls=%0d bub=%0d mdr=%h rw=%b m2r=%b alu=%h rd=%0d mis=%b, required %0d 0 %h %b %b %h %0d %b",
                             d, n, s, bb, mdr[d], mw_rw[d], mw_m2r[d], mw_alu[d], mw_rd[d], mw_mis[d],
                             exp_s, ref_mdr[d], rw & !mis, m2r, addr, rdi, mis);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_word_lat0;
        test_subword;
        test_wrap;
        test_latency;
        test_reset_in_wait;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
